sc_instr_encoder_loader: RTL and testbench

//  Assembles symbolic instructions (mnemonic plus fields) into 32-bit MIPS words and streams them into instruction memory.
//  It is the encoder counterpart of the single-cycle control decoder: it emits exactly the op/func codes that decoder recognises.

---
 rtl/sc_isa_pkg.sv | 67 ++++++
 rtl/sc_instr_encode.sv | 45 ++++
 rtl/sc_instr_encoder_loader.sv | 118 +++++++++++
 tb/tb_sc_instr_encoder_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_isa_pkg.sv
// Shared ISA definitions for the single-cycle core: mnemonic codes, opcode/func
// constants and field positions, used by both the encoder/loader and the control decoder.
package sc_isa_pkg;

  localparam logic [4:0] MN_ADD  = 5'd0;
  localparam logic [4:0] MN_SUB  = 5'd1;
  localparam logic [4:0] MN_AND  = 5'd2;
  localparam logic [4:0] MN_OR   = 5'd3;
  localparam logic [4:0] MN_XOR  = 5'd4;
  localparam logic [4:0] MN_SLL  = 5'd5;
  localparam logic [4:0] MN_SRL  = 5'd6;
  localparam logic [4:0] MN_SRA  = 5'd7;
  localparam logic [4:0] MN_JR   = 5'd8;
  localparam logic [4:0] MN_ADDI = 5'd9;
  localparam logic [4:0] MN_ANDI = 5'd10;
  localparam logic [4:0] MN_ORI  = 5'd11;
  localparam logic [4:0] MN_XORI = 5'd12;
  localparam logic [4:0] MN_LW   = 5'd13;
  localparam logic [4:0] MN_SW   = 5'd14;
  localparam logic [4:0] MN_BEQ  = 5'd15;
  localparam logic [4:0] MN_BNE  = 5'd16;
  localparam logic [4:0] MN_LUI  = 5'd17;
  localparam logic [4:0] MN_J    = 5'd18;
  localparam logic [4:0] MN_JAL  = 5'd19;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNC_SLL = 6'h00;
  localparam logic [5:0] FUNC_SRL = 6'h02;
  localparam logic [5:0] FUNC_SRA = 6'h03;
  localparam logic [5:0] FUNC_JR  = 6'h08;
  localparam logic [5:0] FUNC_ADD = 6'h20;
  localparam logic [5:0] FUNC_SUB = 6'h22;
  localparam logic [5:0] FUNC_AND = 6'h24;
  localparam logic [5:0] FUNC_OR  = 6'h25;
  localparam logic [5:0] FUNC_XOR = 6'h26;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} ld_state_t;

  function automatic logic [31:0] r_word(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                         logic [4:0] shamt, logic [5:0] func);
    return {OP_RTYPE, rs, rt, rd, shamt, func};
  endfunction

  function automatic logic [31:0] i_word(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                         logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/sc_instr_encode.sv
// Combinational assembler: symbolic mnemonic plus fields -> 32-bit MIPS word.
// Fields an instruction does not use are zeroed so the decoder sees canonical encodings.
module sc_instr_encode
  import sc_isa_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (mnem)
      MN_ADD:  word = r_word(rs, rt, rd, 5'd0, FUNC_ADD);
      MN_SUB:  word = r_word(rs, rt, rd, 5'd0, FUNC_SUB);
      MN_AND:  word = r_word(rs, rt, rd, 5'd0, FUNC_AND);
      MN_OR:   word = r_word(rs, rt, rd, 5'd0, FUNC_OR);
      MN_XOR:  word = r_word(rs, rt, rd, 5'd0, FUNC_XOR);
      MN_SLL:  word = r_word(5'd0, rt, rd, shamt, FUNC_SLL);
      MN_SRL:  word = r_word(5'd0, rt, rd, shamt, FUNC_SRL);
      MN_SRA:  word = r_word(5'd0, rt, rd, shamt, FUNC_SRA);
      MN_JR:   word = r_word(rs, 5'd0, 5'd0, 5'd0, FUNC_JR);
      MN_ADDI: word = i_word(OP_ADDI, rs, rt, imm);
      MN_ANDI: word = i_word(OP_ANDI, rs, rt, imm);
      MN_ORI:  word = i_word(OP_ORI, rs, rt, imm);
      MN_XORI: word = i_word(OP_XORI, rs, rt, imm);
      MN_LW:   word = i_word(OP_LW, rs, rt, imm);
      MN_SW:   word = i_word(OP_SW, rs, rt, imm);
      MN_BEQ:  word = i_word(OP_BEQ, rs, rt, imm);
      MN_BNE:  word = i_word(OP_BNE, rs, rt, imm);
      MN_LUI:  word = i_word(OP_LUI, 5'd0, rt, imm);
      MN_J:    word = {OP_J, target};
      MN_JAL:  word = {OP_JAL, target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/sc_instr_encoder_loader.sv
// Streams assembled instructions into imem through a 1-entry output register.
// Optional ENC_CHECKSUM_EN adds a checksum port: XOR of all words written this session.
module sc_instr_encoder_loader
  import sc_isa_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_cnt,
  output logic              err_illegal,
  output logic              wrapped
`ifdef ENC_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  ld_state_t         state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic              accept, push, wr_done, sess_start;

  sc_instr_encode u_enc (
    .mnem    (in_mnem),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .shamt   (in_shamt),
    .imm     (in_imm),
    .target  (in_target),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign in_ready   = (state == ST_LOAD) && (!imem_we || imem_ready);
  assign accept     = in_valid && in_ready;
  assign push       = accept && !enc_illegal;
  assign wr_done    = imem_we && imem_ready;
  assign sess_start = (state == ST_IDLE) && start;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_LOAD;
      ST_LOAD:  if (accept && in_last) state_nx = ST_DRAIN;
      ST_DRAIN: if (!imem_we) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // addr is the next address to hand out; it advances at acceptance so a new
  // word can be loaded in the same cycle the previous one retires.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      addr        <= '0;
      word_cnt    <= '0;
      err_illegal <= 1'b0;
      wrapped     <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
    end else begin
      state <= state_nx;
      if (sess_start) begin
        addr        <= base_addr;
        word_cnt    <= '0;
        err_illegal <= 1'b0;
        wrapped     <= 1'b0;
      end else begin
        if (accept && enc_illegal) err_illegal <= 1'b1;
        if (push) addr <= addr + ADDR_W'(1);
        if (wr_done) begin
          word_cnt <= word_cnt + (ADDR_W+1)'(1);
          if (&imem_addr) wrapped <= 1'b1;
        end
      end
      if (push) begin
        imem_we    <= 1'b1;
        imem_addr  <= addr;
        imem_wdata <= enc_word;
      end else if (wr_done) begin
        imem_we <= 1'b0;
      end
    end
  end

`ifdef ENC_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (!resetn || sess_start) checksum <= '0;
    else if (wr_done)          checksum <= checksum ^ imem_wdata;
  end
`endif

endmodule

// File: tb/tb_sc_instr_encoder_loader.sv
// Randomized bench for sc_instr_encoder_loader against an arithmetic reference encoder and write scoreboard.
module tb_sc_instr_encoder_loader;
  localparam int ADDR_W = 8;

  logic              clock = 0, resetn = 0, start = 0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              in_valid = 0, in_ready, in_last = 0;
  logic [4:0]        in_mnem = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0]       in_imm = '0;
  logic [25:0]       in_target = '0;
  logic              imem_we, imem_ready = 0;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy, done, err_illegal, wrapped;
  logic [ADDR_W:0]   word_cnt;
`ifdef ENC_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  sc_instr_encoder_loader #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .resetn(resetn), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .imem_we(imem_we),
    .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .word_cnt(word_cnt), .err_illegal(err_illegal),
    .wrapped(wrapped)
`ifdef ENC_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int mnem, rs, rt, rd, sh, imm, tgt;
  } instr_t;

  int      checks = 0, failures = 0;
  int      rdy_mode = 0;          // 0 random, 1 held low, 2 held high
  instr_t  prog[$];
  int      exp_addr[$];
  longint  exp_word[$];
  int      log_addr[$];
  longint  log_word[$];
  int      m_addr, m_cnt;
  bit      m_err, m_wrap;
  longint  m_sum;
  bit      stall = 0;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference assembler from the ISA tables; bit 32 flags an illegal mnemonic.
  function automatic longint ref_enc(instr_t x);
    longint rs = x.rs, rt = x.rt, rd = x.rd, sh = x.sh, imm = x.imm, op, fn;
    int m = x.mnem;
    if (m > 19) return 64'h1_0000_0000;
    if (m <= 8) begin
      case (m)
        0: fn = 32; 1: fn = 34; 2: fn = 36; 3: fn = 37; 4: fn = 38;
        5: fn = 0;  6: fn = 2;  7: fn = 3;  default: fn = 8;
      endcase
      if (m >= 5 && m <= 7) rs = 0; else sh = 0;
      if (m == 8) begin rt = 0; rd = 0; end
      return rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + sh * 64 + fn;
    end
    if (m >= 18) return (m - 16) * (64'd1 << 26) + x.tgt;
    case (m)
      9: op = 8;   10: op = 12; 11: op = 13; 12: op = 14; 13: op = 35;
      14: op = 43; 15: op = 4;  16: op = 5;  default: op = 15;
    endcase
    if (m == 17) rs = 0;
    return op * (64'd1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
  endfunction

  function automatic instr_t mk(int m, int rs, int rt, int rd, int sh, int imm, int tgt);
    instr_t x;
    x.mnem = m; x.rs = rs; x.rt = rt; x.rd = rd; x.sh = sh; x.imm = imm; x.tgt = tgt;
    return x;
  endfunction

  function automatic instr_t rnd_instr(int ill_pct);
    int m = ($urandom_range(0, 99) < ill_pct) ? $urandom_range(20, 31) : $urandom_range(0, 19);
    return mk(m, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, (1 << 26) - 1));
  endfunction

  initial forever begin
    @(posedge clock); #1;
    case (rdy_mode)
      0:       imem_ready = ($urandom_range(0, 99) < 70);
      1:       imem_ready = 1'b0;
      default: imem_ready = 1'b1;
    endcase
  end

  // Write scoreboard and handshake-protocol monitor.
  always @(negedge clock) begin
    if (!resetn) begin
      exp_addr.delete(); exp_word.delete(); stall = 0;
    end else begin
      if (stall) begin
        chk("hold_we", imem_we, 1);
        chk("hold_addr", imem_addr, s_addr);
        chk("hold_data", imem_wdata, s_data);
      end
      if (imem_we && !imem_ready) chk("stall_in_ready", in_ready, 0);
      if (!busy) chk("idle_in_ready", in_ready, 0);
      if (imem_we && imem_ready) begin
        log_addr.push_back(imem_addr);
        log_word.push_back(imem_wdata);
        if (exp_addr.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          chk("wr_addr", imem_addr, exp_addr.pop_front());
          chk("wr_data", imem_wdata, exp_word.pop_front());
        end
      end
      stall  = imem_we && !imem_ready;
      s_addr = imem_addr;
      s_data = imem_wdata;
    end
  end

  task automatic run_session(input int base, input int stall_cyc, input bit spur_start);
    int t;
    longint r;
    @(posedge clock); #1;
    start = 1; base_addr = ADDR_W'(base);
    @(posedge clock); #1;
    start = 0;
    m_addr = base; m_cnt = 0; m_err = 0; m_wrap = 0; m_sum = 0;
    log_addr.delete(); log_word.delete();
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < prog.size(); i++) begin
      in_valid = 0;
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
      in_valid = 1; in_mnem = prog[i].mnem[4:0]; in_rs = prog[i].rs[4:0];
      in_rt = prog[i].rt[4:0]; in_rd = prog[i].rd[4:0]; in_shamt = prog[i].sh[4:0];
      in_imm = prog[i].imm[15:0]; in_target = prog[i].tgt[25:0];
      in_last = (i == prog.size() - 1);
      if (spur_start && i == 1) begin start = 1; base_addr = ADDR_W'($urandom); end
      t = 0;
      forever begin
        @(negedge clock);
        if (in_ready) break;
        if (++t > 200) begin chk("accept_timeout", 1, 0); break; end
        @(posedge clock); #1; start = 0;
      end
      r = ref_enc(prog[i]);
      if (r[32]) m_err = 1;
      else begin
        exp_addr.push_back(m_addr); exp_word.push_back(r);
        m_cnt++; m_sum ^= r;
        if (m_addr == (1 << ADDR_W) - 1) m_wrap = 1;
        m_addr = (m_addr + 1) % (1 << ADDR_W);
      end
      @(posedge clock); #1; start = 0;
    end
    in_valid = 0; in_last = 0;
    repeat (stall_cyc) begin
      @(negedge clock);
      chk("stall_we", imem_we, 1);
      chk("stall_done", done, 0);
    end
    if (stall_cyc > 0) rdy_mode = 2;
    t = 0;
    forever begin
      @(negedge clock);
      if (done) break;
      if (++t > 300) begin chk("done_timeout", 1, 0); break; end
    end
    chk("word_cnt", word_cnt, m_cnt);
    chk("err_illegal", err_illegal, m_err);
    chk("wrapped", wrapped, m_wrap);
    chk("pending_left", exp_addr.size(), 0);
`ifdef ENC_CHECKSUM_EN
    chk("checksum", checksum, m_sum);
`endif
    @(negedge clock);
    chk("done_pulse_end", done, 0);
    chk("idle_after_done", busy, 0);
`ifdef ENC_CHECKSUM_EN
    chk("checksum_stable", checksum, m_sum);
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, imem_we, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cnt"}, word_cnt, 0);
    chk({tag, "_err"}, err_illegal, 0);
    chk({tag, "_wrap"}, wrapped, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 chk_zero("reset");
    resetn = 1;

    rdy_mode = 2;
    prog.delete(); prog.push_back(mk(0, 1, 2, 3, 9, 0, 0));
    run_session('h10, 0, 0);
    chk("t1_addr", log_addr[0], 'h10);
    chk("t1_data", log_word[0], 32'h00221820);

    rdy_mode = 0;
    prog.delete();
    prog.push_back(mk(13, 5, 4, 0, 0, 8, 0));
    prog.push_back(mk(5, 7, 3, 2, 4, 0, 0));
    run_session('h40, 0, 0);
    chk("t2_lw", log_word[0], 32'h8CA40008);
    chk("t2_sll", log_word[1], 32'h00031100);

    rdy_mode = 1;
    prog.delete(); prog.push_back(mk(19, 0, 0, 0, 0, 0, 'h10));
    run_session('h80, 3, 0);
    chk("t3_jal", log_word[0], 32'h0C000010);

    rdy_mode = 0;
    prog.delete();
    prog.push_back(mk(9, 1, 2, 0, 0, 5, 0));
    prog.push_back(mk(25, 1, 2, 3, 0, 0, 0));
    prog.push_back(mk(9, 3, 4, 0, 0, 6, 0));
    run_session('h30, 0, 0);
    chk("t4_consec", log_addr[1], log_addr[0] + 1);

    prog.delete();
    prog.push_back(mk(1, 1, 2, 3, 0, 0, 0));
    prog.push_back(mk(18, 0, 0, 0, 0, 0, 'h123456));
    run_session('hFF, 0, 1);
    chk("t5_a0", log_addr[0], 'hFF);
    chk("t5_a1", log_addr[1], 0);

    for (int s = 0; s < 20; s++) begin
      prog.delete();
      for (int i = $urandom_range(1, 12); i > 0; i--) prog.push_back(rnd_instr(15));
      run_session((s % 4 == 0) ? $urandom_range(248, 255) : $urandom_range(0, 255), 0, $urandom_range(0, 1));
    end

    // Reset with a write still pending.
    rdy_mode = 1;
    @(posedge clock); #1 start = 1; base_addr = 'h20;
    @(posedge clock); #1 start = 0;
    in_valid = 1; in_mnem = 0; in_rs = 1; in_rt = 2; in_rd = 3; in_last = 0;
    @(posedge clock); #1 in_valid = 0;
    @(posedge clock); #1 chk("rst_pending_we", imem_we, 1);
    resetn = 0;
    @(posedge clock); #1 chk_zero("midrst");
    resetn = 1;

    // in_valid while idle must not produce writes.
    rdy_mode = 2;
    in_valid = 1;
    repeat (5) @(posedge clock);
    #1 chk("idle_valid_we", imem_we, 0);
    chk("idle_valid_busy", busy, 0);
    in_valid = 0;
    repeat (2) @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule
